// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - shared constants for the UDP payload extractor
//   FSM state encoding, protocol constants and an IPv4 address byte selector.
package udp_rx_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ETH_TYPE = 3'd1;
  localparam logic [2:0] ST_IP_HDR   = 3'd2;
  localparam logic [2:0] ST_UDP_HDR  = 3'd3;
  localparam logic [2:0] ST_PAYLOAD  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_DROP     = 3'd6;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

  // Byte idx of an IPv4 address in wire order (0 = most significant).
  function automatic logic [7:0] ip_addr_byte(input logic [31:0] addr, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr[31:24];
      2'd1:    b = addr[23:16];
      2'd2:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// rtl/ip_hdr_csum.sv - byte-serial 16-bit ones-complement accumulator for the IPv4 header
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the sum (held while not inside the IP header)
//   en         : accumulate csum_byte (bytes arrive MSB first, pairs form 16-bit words)
//   csum_byte  : header byte
//   sum_ok     : on the second byte of a word, the sum including that byte is 16'hFFFF
module ip_hdr_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] csum_byte,
  output logic       sum_ok
);

  logic [15:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic        odd_q, odd_d;
  logic [16:0] sum17;
  logic [15:0] folded;

  always_comb begin
    sum17  = {1'b0, acc_q} + {1'b0, hi_q, csum_byte};
    // One end-around carry is enough: the 17-bit sum never exceeds 17'h1FFFE.
    folded = sum17[15:0] + {15'd0, sum17[16]};
    acc_d  = acc_q;
    hi_d   = hi_q;
    odd_d  = odd_q;
    if (clr) begin
      acc_d = 16'd0;
      hi_d  = 8'd0;
      odd_d = 1'b0;
    end else if (en) begin
      if (odd_q) begin
        acc_d = folded;
        odd_d = 1'b0;
      end else begin
        hi_d  = csum_byte;
        odd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 16'd0;
      hi_q  <= 8'd0;
      odd_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      hi_q  <= hi_d;
      odd_q <= odd_d;
    end
  end

  assign sum_ok = odd_q && (folded == 16'hFFFF);

endmodule

// File: rtl/udp_payload_extract.sv
// rtl/udp_payload_extract.sv - strip EtherType/IPv4/UDP headers, emit UDP payload for this board
//   Optional IPv4 header checksum check: define UDP_IP_CSUM_CHECK_EN.
//   phy_rx_clk, reset_n        : clock, asynchronous active-low reset
//   in_data/in_valid/in_frame  : received byte stream, in_frame falling edge ends the frame
//   pl_data/pl_valid           : payload byte (registered, one cycle after the input byte)
//   pl_sof/pl_eof/pl_abort     : first byte, last byte, frame cut short inside the payload
//   pl_len                     : payload length, updated together with pl_sof
//   drop_cnt                   : saturating count of rejected frames
//   status                     : current FSM state
module udp_payload_extract
  import udp_rx_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        phy_rx_clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_frame,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_sof,
  output logic        pl_eof,
  output logic        pl_abort,
  output logic [15:0] pl_len,
  output logic [15:0] drop_cnt,
  output logic [2:0]  status
);

  logic [2:0]  state_q, state_d;
  logic [5:0]  hdr_cnt_q, hdr_cnt_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] pl_remain_q, pl_remain_d;
  logic        first_q, first_d;
  logic        armed_q, armed_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_valid_q, pl_valid_d;
  logic        pl_sof_q, pl_sof_d;
  logic        pl_eof_q, pl_eof_d;
  logic        pl_abort_q, pl_abort_d;
  logic [15:0] pl_len_q, pl_len_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        drop_inc;
  logic        fail;
  logic [15:0] ip_hdr_len;
  logic        ip_last;
  logic        csum_bad;

  assign ip_hdr_len = {10'd0, ihl_q, 2'b00};
  assign ip_last    = ({10'd0, hdr_cnt_q} == (ip_hdr_len - 16'd1));

`ifdef UDP_IP_CSUM_CHECK_EN
  logic csum_ok;

  ip_hdr_csum u_csum (
    .clk       (phy_rx_clk),
    .rst_n     (reset_n),
    .clr       (state_q != ST_IP_HDR),
    .en        (in_valid && (state_q == ST_IP_HDR)),
    .csum_byte (in_data),
    .sum_ok    (csum_ok)
  );

  assign csum_bad = !csum_ok;
`else
  assign csum_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    ihl_d       = ihl_q;
    hold_d      = hold_q;
    udp_len_d   = udp_len_q;
    pl_remain_d = pl_remain_q;
    first_d     = first_q;
    armed_d     = armed_q;
    pl_data_d   = pl_data_q;
    pl_valid_d  = 1'b0;
    pl_sof_d    = 1'b0;
    pl_eof_d    = 1'b0;
    pl_abort_d  = 1'b0;
    pl_len_d    = pl_len_q;
    drop_cnt_d  = drop_cnt_q;
    drop_inc    = 1'b0;
    fail        = 1'b0;

    // A new frame may only start once in_frame has been seen low.
    if (!in_frame) armed_d = 1'b1;

    // Byte processing first; frame-end handling below acts on the resulting state.
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_frame && armed_q) begin
          hold_d  = in_data;
          armed_d = 1'b0;
          state_d = ST_ETH_TYPE;
        end
      end
      ST_ETH_TYPE: begin
        if (in_valid) begin
          if ({hold_q, in_data} == ETHERTYPE_IPV4) begin
            hdr_cnt_d = 6'd0;
            state_d   = ST_IP_HDR;
          end else begin
            fail = 1'b1;
          end
        end
      end
      ST_IP_HDR: begin
        if (in_valid) begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q == 6'd0) begin
            ihl_d = in_data[3:0];
            if (in_data[7:4] != 4'd4 || in_data[3:0] < 4'd5) fail = 1'b1;
          end
          if (hdr_cnt_q == 6'd9 && in_data != IP_PROTO_UDP) fail = 1'b1;
          if (hdr_cnt_q >= 6'd16 && hdr_cnt_q <= 6'd19 &&
              in_data != ip_addr_byte(LOCAL_IP, hdr_cnt_q[1:0])) fail = 1'b1;
          // ihl_q is only meaningful after byte 0, hence the guard.
          if (hdr_cnt_q != 6'd0 && ip_last) begin
            if (csum_bad) begin
              fail = 1'b1;
            end else if (!fail) begin
              hdr_cnt_d = 6'd0;
              state_d   = ST_UDP_HDR;
            end
          end
        end
      end
      ST_UDP_HDR: begin
        if (in_valid) begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          case (hdr_cnt_q)
            6'd2: hold_d = in_data;
            6'd3: if ({hold_q, in_data} != LOCAL_PORT) fail = 1'b1;
            6'd4: hold_d = in_data;
            6'd5: begin
              udp_len_d = {hold_q, in_data};
              if ({hold_q, in_data} <= UDP_HDR_LEN) fail = 1'b1;
            end
            6'd7: begin
              pl_remain_d = udp_len_q - UDP_HDR_LEN;
              first_d     = 1'b1;
              state_d     = ST_PAYLOAD;
            end
            default: ;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          pl_valid_d  = 1'b1;
          pl_data_d   = in_data;
          pl_sof_d    = first_q;
          // pl_len changes together with pl_sof so it stays stable for the whole frame.
          if (first_q) pl_len_d = udp_len_q - UDP_HDR_LEN;
          first_d     = 1'b0;
          pl_remain_d = pl_remain_q - 16'd1;
          if (pl_remain_q == 16'd1) begin
            pl_eof_d = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      default: ;
    endcase

    if (fail) begin
      state_d  = ST_DROP;
      drop_inc = 1'b1;
    end

    if (!in_frame) begin
      case (state_d)
        ST_ETH_TYPE, ST_IP_HDR, ST_UDP_HDR: begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_PAYLOAD: begin
          pl_abort_d = 1'b1;
          drop_inc   = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_DONE, ST_DROP: state_d = ST_IDLE;
        default: ;
      endcase
    end

    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge phy_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      hdr_cnt_q   <= 6'd0;
      ihl_q       <= 4'd0;
      hold_q      <= 8'd0;
      udp_len_q   <= 16'd0;
      pl_remain_q <= 16'd0;
      first_q     <= 1'b0;
      armed_q     <= 1'b0;
      pl_data_q   <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_sof_q    <= 1'b0;
      pl_eof_q    <= 1'b0;
      pl_abort_q  <= 1'b0;
      pl_len_q    <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      ihl_q       <= ihl_d;
      hold_q      <= hold_d;
      udp_len_q   <= udp_len_d;
      pl_remain_q <= pl_remain_d;
      first_q     <= first_d;
      armed_q     <= armed_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_sof_q    <= pl_sof_d;
      pl_eof_q    <= pl_eof_d;
      pl_abort_q  <= pl_abort_d;
      pl_len_q    <= pl_len_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign pl_data  = pl_data_q;
  assign pl_valid = pl_valid_q;
  assign pl_sof   = pl_sof_q;
  assign pl_eof   = pl_eof_q;
  assign pl_abort = pl_abort_q;
  assign pl_len   = pl_len_q;
  assign drop_cnt = drop_cnt_q;
  assign status   = state_q;

endmodule

// File: tb/tb_udp_payload_extract.sv
// tb/tb_udp_payload_extract.sv - randomized bench for udp_payload_extract against a frame-parsing model
module tb_udp_payload_extract;

  localparam logic [31:0] LIP   = 32'hC0A8_0102;
  localparam logic [15:0] LPORT = 16'd8080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_frame;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_sof, pl_eof, pl_abort;
  logic [15:0] pl_len, drop_cnt;
  logic [2:0]  status;

  udp_payload_extract #(.LOCAL_IP(LIP), .LOCAL_PORT(LPORT)) dut (
    .phy_rx_clk (clk),
    .reset_n    (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_frame   (in_frame),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_sof     (pl_sof),
    .pl_eof     (pl_eof),
    .pl_abort   (pl_abort),
    .pl_len     (pl_len),
    .drop_cnt   (drop_cnt),
    .status     (status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_drop = 0;

  logic [7:0] fb[$];
  logic [7:0] cap_d[$];
  bit         cap_s[$];
  bit         cap_e[$];
  int         abort_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pl_valid) begin
        cap_d.push_back(pl_data);
        cap_s.push_back(pl_sof);
        cap_e.push_back(pl_eof);
      end
      if (pl_abort) abort_n++;
    end
  end

  function automatic logic [15:0] ocsum(input logic [7:0] h[$], input int len);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < len; i += 2) s += {16'd0, h[i], h[i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic build(input logic [15:0] etype, input logic [3:0] ver, input logic [3:0] ihl,
                       input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                       input logic [15:0] ulen, input int pad, input bit csum_err);
    logic [7:0]  h[$];
    logic [15:0] cs;
    int hlen;
    int npay;
    fb.delete();
    fb.push_back(etype[15:8]);
    fb.push_back(etype[7:0]);
    hlen = (ihl < 4'd5) ? 20 : int'(ihl) * 4;
    for (int i = 0; i < hlen; i++) h.push_back(8'($urandom));
    h[0] = {ver, ihl};
    h[9] = proto;
    h[10] = 8'd0;
    h[11] = 8'd0;
    h[16] = dip[31:24]; h[17] = dip[23:16]; h[18] = dip[15:8]; h[19] = dip[7:0];
    cs = ~ocsum(h, hlen) + {15'd0, csum_err};
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    foreach (h[i]) fb.push_back(h[i]);
    fb.push_back(8'($urandom)); fb.push_back(8'($urandom));
    fb.push_back(dport[15:8]);  fb.push_back(dport[7:0]);
    fb.push_back(ulen[15:8]);   fb.push_back(ulen[7:0]);
    fb.push_back(8'($urandom)); fb.push_back(8'($urandom));
    npay = (ulen > 16'd8) ? int'(ulen) - 8 : 0;
    for (int i = 0; i < npay + pad; i++) fb.push_back(8'($urandom));
  endtask

  // Reference: decide from the whole frame whether its headers are acceptable, then
  // account for how many bytes were actually delivered before in_frame fell.
  task automatic model(input int n, output int ecnt, output bit eeof, output bit eabort,
                       output int hend, output int plen);
    bit ok;
    int ihl;
    int u;
    logic [7:0]  b0;
    logic [15:0] ulen;
    logic [7:0]  h[$];
    b0 = fb[2];
    ihl = int'(b0[3:0]);
    ok = ({fb[0], fb[1]} == 16'h0800) && (b0[7:4] == 4'd4) && (ihl >= 5);
    ecnt = 0; eeof = 0; eabort = 0; hend = 0; plen = 0;
    if (ok) begin
      u = 2 + ihl * 4;
      hend = u + 8;
      ok = (fb[11] == 8'd17) && ({fb[18], fb[19], fb[20], fb[21]} == LIP) &&
           ({fb[u+2], fb[u+3]} == LPORT);
      ulen = {fb[u+4], fb[u+5]};
      if (ulen <= 16'd8) ok = 0;
      plen = int'(ulen) - 8;
`ifdef UDP_IP_CSUM_CHECK_EN
      for (int i = 0; i < ihl * 4; i++) h.push_back(fb[2+i]);
      if (ocsum(h, ihl * 4) != 16'hFFFF) ok = 0;
`endif
    end
    if (!ok || n < hend) begin
      exp_drop++;
    end else if (n - hend >= plen) begin
      ecnt = plen;
      eeof = 1;
    end else begin
      ecnt = n - hend;
      eabort = 1;
      exp_drop++;
    end
  endtask

  task automatic drive(input int n, input bit same_end);
    in_frame = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = fb[i];
      if (same_end && i == n - 1) in_frame = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input int n, input bit same_end);
    int ecnt, hend, plen, nsof, neof;
    bit eeof, eabort;
    cap_d.delete(); cap_s.delete(); cap_e.delete();
    abort_n = 0;
    drive(n, same_end && n > 1);
    in_frame = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    model(n, ecnt, eeof, eabort, hend, plen);
    nsof = 0; neof = 0;
    foreach (cap_s[i]) begin
      nsof += int'(cap_s[i]);
      neof += int'(cap_e[i]);
    end
    chk("pl_count", cap_d.size(), ecnt);
    for (int i = 0; i < cap_d.size() && i < ecnt; i++) chk("pl_data", cap_d[i], fb[hend+i]);
    chk("sof_count", nsof, (ecnt > 0) ? 1 : 0);
    if (ecnt > 0 && cap_s.size() > 0) chk("sof_first", cap_s[0], 1);
    chk("eof_count", neof, eeof);
    if (eeof && cap_e.size() > 0) chk("eof_last", cap_e[cap_e.size()-1], 1);
    chk("abort", abort_n, eabort);
    chk("drop_cnt", drop_cnt, exp_drop);
    chk("status_idle", status, 0);
    if (ecnt > 0) chk("pl_len", pl_len, plen);
  endtask

  initial begin
    int r, n;
    logic [15:0] et, dp, ul;
    logic [3:0]  ver, ihl;
    logic [7:0]  pr;
    logic [31:0] dip;
    bit          ce;

    rst_n = 1'b0; in_data = 8'd0; in_valid = 1'b0; in_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {pl_data, pl_valid, pl_sof, pl_eof, pl_abort}, 0);
    chk("rst_pl_len", pl_len, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_status", status, 0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    build(16'h0800, 4, 5, 17, LIP, LPORT, 16, 0, 0);   run_frame(fb.size(), 0);
    build(16'h0806, 4, 5, 17, LIP, LPORT, 16, 0, 0);   run_frame(fb.size(), 0);
    build(16'h0800, 4, 5, 17, LIP, LPORT, 12, 50, 0);  run_frame(fb.size(), 0);
    build(16'h0800, 4, 5, 17, LIP, LPORT, 16, 0, 0);   run_frame(30 + 3, 0);
    build(16'h0800, 4, 6, 17, LIP, LPORT, 20, 4, 0);   run_frame(fb.size(), 0);
    build(16'h0800, 4, 5, 17, LIP, LPORT, 16, 0, 1);   run_frame(fb.size(), 0);
    build(16'h0800, 4, 5, 17, LIP, LPORT, 9, 3, 0);    run_frame(fb.size(), 1);

    for (int k = 0; k < 50; k++) begin
      et = 16'h0800; ver = 4'd4; ihl = 4'($urandom_range(5, 8)); pr = 8'd17;
      dip = LIP; dp = LPORT; ul = 16'($urandom_range(9, 40)); ce = 0;
      r = $urandom_range(0, 11);
      case (r)
        0: et = 16'h86DD;
        1: ihl = 4'($urandom_range(0, 4));
        2: ver = 4'd6;
        3: pr = 8'd6;
        4: dip = LIP ^ (32'd1 << $urandom_range(0, 31));
        5: dp = LPORT + 16'd1;
        6: ul = 16'($urandom_range(0, 8));
        7: ce = 1;
        default: ;
      endcase
      build(et, ver, ihl, pr, dip, dp, ul, $urandom_range(0, 20), ce);
      n = fb.size();
      if (r == 8 || r == 9) n = $urandom_range(1, fb.size());
      run_frame(n, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a payload: outputs clear at once, no abort follows.
    build(16'h0800, 4, 5, 17, LIP, LPORT, 30, 0, 0);
    cap_d.delete(); cap_s.delete(); cap_e.delete();
    abort_n = 0;
    drive(40, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", pl_valid, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_status", status, 0);
    in_frame = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_abort", abort_n, 0);
    exp_drop = 0;
    build(16'h0800, 4, 7, 17, LIP, LPORT, 25, 5, 0);
    run_frame(fb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
